dmem_arb: RTL and testbench
===========================

# dmem_arb

Two-master arbiter sharing the single core data-memory port between the data pipeline unit (master 0) and a secondary requester such as the page-table walker or debug access (master 1). Adds zero latency: requests and responses pass combinationally, and the block only registers the outstanding owner and the round-robin pointer. It sits between both masters and the dmem interface and preserves the accept/complete protocol each master already uses. Fault and exclusive-status returns are routed only to the owning master.

## Interface
- ADDR_W, `DM_ADDR_LEN: address width
- DATA_W, `DM_DATA_LEN: data width; byte-enable width is DATA_W/8
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- mN_req  in  1  request from master N (N=0,1)
- mN_addr  in  ADDR_W  request address
- mN_wr  in  1  write request
- mN_ex  in  1  exclusive/atomic request
- mN_byte  in  DATA_W/8  byte enables
- mN_wdata  in  DATA_W  write data
- mN_rdata  out  DATA_W  read data (broadcast of dmem_rdata)
- mN_bad  out  2  fault status, gated to the owner
- mN_xstate  out  1  exclusive status, gated to the owner
- mN_busy  out  1  per-master busy
- dmem_req, dmem_addr, dmem_wr, dmem_ex, dmem_byte, dmem_wdata  out  1/ADDR_W/1/1/DATA_W/8/DATA_W  downstream request, muxed from the selected master
- dmem_rdata  in  DATA_W  downstream read data
- dmem_bad  in  2  downstream fault status
- dmem_xstate  in  1  downstream exclusive status
- dmem_busy  in  1  downstream busy
- dmem_owner  out  2  one-hot owner of the outstanding transaction (trace)

## Operation
- Downstream protocol, unchanged for each master:
  - A request is accepted in any cycle where req & ~busy.
  - Its response (rdata/bad/xstate) completes in the first later cycle where busy=0.
  - That completion cycle is also an accept opportunity.
- Registers:
  - own: one-hot, 00 = none.
  - rr: 0 = master 0 favoured.
- Preferred master P each cycle:
  - P = the owner if own≠00; otherwise P = rr.
  - O = the other master.
- Busy generation (loop-free, because masters gate req with their own busy):
  - P_busy = dmem_busy.
  - O_busy = dmem_busy | P_req.
- Mux:
  - dmem_req = P_req | O_req.
  - All dmem_* request fields come from P when P_req=1, else from O.
- Accept is dmem_req & ~dmem_busy:
  - own <= one-hot of the accepted master.
  - rr <= the other master index.
- Completion without a new accept (own≠00, ~dmem_busy, ~dmem_req): own <= 00, rr unchanged.
- Owner continuation is unconditional:
  - An owner requesting in its completion cycle always wins.
  - This keeps the DPU's AMO read→write pair atomic and lets a master issue back-to-back.
- Response routing:
  - mN_rdata = dmem_rdata for both masters.
  - mN_bad = dmem_bad & {2{own[N]}}.
  - mN_xstate = dmem_xstate & own[N].
- dmem_owner = own.

## Timing
- Reset values:
  - own=00, rr=0, dmem_owner=00.
  - dmem_req=0 while neither master requests.
  - mN_bad=0 and mN_xstate=0.
  - m0_busy=dmem_busy.
  - m1_busy=dmem_busy | m0_req.
- Arbitration is combinational; request-to-dmem latency is 0 cycles; response latency is whatever the downstream adds.
- Simultaneous requests with own=00: rr wins, and the loser sees busy=1 until it is accepted.
- Same cycle as a completion: a new accept by either master is allowed; own switches directly with no idle cycle.
- Fault on completion: only the owner sees bad≠0; the other master's bad stays 0 even if it is accepted in that cycle.
- Reset mid-transaction: own clears asynchronously; any response arriving after reset release is routed to no one (bad/xstate=0 to both).
- Masters must hold their request fields stable while their busy=1; the arbiter does not latch request fields.

## Test plan
- m0 load, then m1 load, then m0 load; dmem_busy toggles 1 cycle each → dmem_owner sequence 01, 10, 01; each master sees its rdata with busy=0 exactly once per request.
- m0 and m1 request in the same cycle after reset → m0 accepted (rr=0), m1_busy=1; next grant point → m1 accepted, rr=0 again.
- m0 issues back-to-back loads for 10 cycles while m1 requests continuously → m0 accepted every cycle, m1_busy stays 1; m0 drops req → m1 accepted in that cycle.
- m0 AMO (read then write) with m1 requesting → no m1 accept between the two m0 accepts; m0_xstate reflects dmem_xstate and m1_xstate=0.
- m1 access completes with dmem_bad=2'b10 while m0 is accepted the same cycle → m1_bad=2'b10, m0_bad=2'b00; own becomes 01.
- rstn asserted low while own=10 and dmem_busy=1 → own=00 immediately; a later dmem_bad=2'b01 yields 0 on both mN_bad.

Source files
------------

// File: rtl/dmem_arb_if.sv
// Data-memory request/response bundle shared by both masters and the dmem port.
// Latency: none, wires only.
// Backpressure: busy from the responder; requester holds fields stable while busy=1.
// Ports: req/addr/wr/ex/byte_en/wdata flow requester->responder;
//        rdata/bad/xstate/busy flow responder->requester.
`ifndef DM_ADDR_LEN
`define DM_ADDR_LEN 32
`endif
`ifndef DM_DATA_LEN
`define DM_DATA_LEN 32
`endif

interface dmem_arb_if #(
  parameter int ADDR_W = `DM_ADDR_LEN,
  parameter int DATA_W = `DM_DATA_LEN
);
  logic                  req;
  logic [ADDR_W-1:0]     addr;
  logic                  wr;
  logic                  ex;
  logic [DATA_W/8-1:0]   byte_en;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            bad;
  logic                  xstate;
  logic                  busy;

  // requester side
  modport master (
    output req, addr, wr, ex, byte_en, wdata,
    input  rdata, bad, xstate, busy
  );

  // responder side
  modport slave (
    input  req, addr, wr, ex, byte_en, wdata,
    output rdata, bad, xstate, busy
  );
endinterface

// File: rtl/dmem_arb.sv
// Two-master round-robin arbiter in front of the single core data-memory port.
// Latency: 0 cycles request->dmem and response->master; only owner and rr pointer are registered.
// Backpressure: preferred master sees dmem busy; the other also sees busy while the preferred one requests.
// Ports: clk, rstn (async active-low); m0/m1 requester bundles (slave side);
//        dmem downstream bundle (master side); dmem_owner one-hot owner trace.
`ifndef DM_ADDR_LEN
`define DM_ADDR_LEN 32
`endif
`ifndef DM_DATA_LEN
`define DM_DATA_LEN 32
`endif

module dmem_arb #(
  parameter int ADDR_W = `DM_ADDR_LEN,
  parameter int DATA_W = `DM_DATA_LEN
) (
  input  logic        clk,
  input  logic        rstn,
  dmem_arb_if.slave   m0,
  dmem_arb_if.slave   m1,
  dmem_arb_if.master  dmem,
  output logic [1:0]  dmem_owner
);

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic                wr;
    logic                ex;
    logic [DATA_W/8-1:0] byte_en;
    logic [DATA_W-1:0]   wdata;
  } req_t;

  logic [1:0] own, own_nxt;   // one-hot owner of the outstanding access, 00 = none
  logic       rr, rr_nxt;     // index of the master favoured when nobody owns the port
  logic       pref;           // preferred master index this cycle
  logic       p_req;          // preferred master is requesting
  logic       sel;            // master whose fields drive dmem
  logic       accept;
  req_t       req0, req1, req_sel;

  // The owner keeps preference so it can continue straight from its completion
  // cycle (keeps AMO read/write pairs atomic and allows back-to-back issue).
  assign pref  = (own != 2'b00) ? own[1] : rr;
  assign p_req = pref ? m1.req : m0.req;
  assign sel   = p_req ? pref : ~pref;

  // No combinational loop: masters gate req with their own busy, and the other
  // master's busy only depends on the preferred master's req.
  assign m0.busy = pref ? (dmem.busy | m1.req) : dmem.busy;
  assign m1.busy = pref ? dmem.busy : (dmem.busy | m0.req);

  assign req0    = '{addr: m0.addr, wr: m0.wr, ex: m0.ex, byte_en: m0.byte_en, wdata: m0.wdata};
  assign req1    = '{addr: m1.addr, wr: m1.wr, ex: m1.ex, byte_en: m1.byte_en, wdata: m1.wdata};
  assign req_sel = sel ? req1 : req0;

  assign dmem.req     = m0.req | m1.req;
  assign dmem.addr    = req_sel.addr;
  assign dmem.wr      = req_sel.wr;
  assign dmem.ex      = req_sel.ex;
  assign dmem.byte_en = req_sel.byte_en;
  assign dmem.wdata   = req_sel.wdata;

  assign accept = dmem.req & ~dmem.busy;

  always_comb begin
    own_nxt = own;
    rr_nxt  = rr;
    if (accept) begin
      own_nxt = sel ? 2'b10 : 2'b01;
      rr_nxt  = ~sel;
    end else if (!dmem.busy) begin
      // completion with nothing new to accept releases the port
      own_nxt = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      own <= 2'b00;
      rr  <= 1'b0;
    end else begin
      own <= own_nxt;
      rr  <= rr_nxt;
    end
  end

  // Read data is broadcast; status goes only to the owner so a master being
  // accepted in the completion cycle never sees the previous owner's fault.
  assign m0.rdata  = dmem.rdata;
  assign m1.rdata  = dmem.rdata;
  assign m0.bad    = dmem.bad & {2{own[0]}};
  assign m1.bad    = dmem.bad & {2{own[1]}};
  assign m0.xstate = dmem.xstate & own[0];
  assign m1.xstate = dmem.xstate & own[1];

  assign dmem_owner = own;

endmodule

// File: tb/tb_dmem_arb.sv
// Scoreboard bench for dmem_arb: directed cycles push expected accepts/completions,
// a negedge monitor pops and compares whenever dmem accepts or a transaction completes.
// Inputs change 1 time unit after posedge; everything is sampled at negedge.
module tb_dmem_arb;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [1:0] dmem_owner;

  always #5 clk = ~clk;

  dmem_arb_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  dmem_arb_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  dmem_arb_if #(.ADDR_W(32), .DATA_W(32)) dmem_if ();

  dmem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .m0         (m0_if),
    .m1         (m1_if),
    .dmem       (dmem_if),
    .dmem_owner (dmem_owner)
  );

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic        wr;
    logic        ex;
  } acc_t;

  typedef struct {
    logic [1:0]  own;
    logic [1:0]  b0;
    logic [1:0]  b1;
    logic        x0;
    logic        x1;
    logic [31:0] rd;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h required=%h at t=%0t", name, got, exp, $time);
  endtask

  task automatic exp_acc(input int m, input logic [31:0] a, input logic w, input logic e);
    acc_t t;
    t.m = m; t.addr = a; t.wr = w; t.ex = e;
    acc_q.push_back(t);
  endtask

  task automatic exp_rsp(input logic [1:0] o, input logic [1:0] b0, input logic [1:0] b1,
                         input logic x0, input logic x1, input logic [31:0] rd);
    rsp_t t;
    t.own = o; t.b0 = b0; t.b1 = b1; t.x0 = x0; t.x1 = x1; t.rd = rd;
    rsp_q.push_back(t);
  endtask

  // drive one cycle's worth of master and downstream inputs
  task automatic set_in(input logic r0, input logic [31:0] a0, input logic w0, input logic e0,
                        input logic r1, input logic [31:0] a1,
                        input logic b, input logic [31:0] rd, input logic [1:0] bd, input logic xs);
    m0_if.req = r0; m0_if.addr = a0; m0_if.wr = w0; m0_if.ex = e0;
    m0_if.byte_en = 4'hF; m0_if.wdata = ~a0;
    m1_if.req = r1; m1_if.addr = a1; m1_if.wr = 1'b0; m1_if.ex = 1'b0;
    m1_if.byte_en = 4'h3; m1_if.wdata = ~a1;
    dmem_if.busy = b; dmem_if.rdata = rd; dmem_if.bad = bd; dmem_if.xstate = xs;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: checks every accept and every completion against the scoreboard
  always @(negedge clk) begin
    if (rstn) begin
      if (dmem_if.req && !dmem_if.busy) begin
        if (acc_q.size() == 0) begin
          n_chk++;
          $display("FAIL acc_unexpected got accept addr=%h, required no accept at t=%0t",
                   dmem_if.addr, $time);
        end else begin
          acc_t e;
          int   got_m;
          e = acc_q.pop_front();
          got_m = (m0_if.req && !m0_if.busy) ? 0 : 1;
          chk("acc_master", got_m, e.m);
          chk("acc_addr", dmem_if.addr, e.addr);
          chk("acc_wdata", dmem_if.wdata, ~e.addr);
          chk("acc_wr", dmem_if.wr, e.wr);
          chk("acc_ex", dmem_if.ex, e.ex);
        end
      end
      if (dmem_owner != 2'b00 && !dmem_if.busy) begin
        if (rsp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rsp_unexpected got completion owner=%b, required none at t=%0t",
                   dmem_owner, $time);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("rsp_owner", dmem_owner, r.own);
          chk("rsp_m0_bad", m0_if.bad, r.b0);
          chk("rsp_m1_bad", m1_if.bad, r.b1);
          chk("rsp_m0_xstate", m0_if.xstate, r.x0);
          chk("rsp_m1_xstate", m1_if.xstate, r.x1);
          chk("rsp_m0_rdata", m0_if.rdata, r.rd);
          chk("rsp_m1_rdata", m1_if.rdata, r.rd);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, checked before the first negedge
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b11, 1);
    chk("rst_owner", dmem_owner, 2'b00);
    chk("rst_dmem_req", dmem_if.req, 1'b0);
    chk("rst_m0_bad", m0_if.bad, 2'b00);
    chk("rst_m1_bad", m1_if.bad, 2'b00);
    chk("rst_m0_xstate", m0_if.xstate, 1'b0);
    chk("rst_m1_xstate", m1_if.xstate, 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 1, 32'h0, 2'b00, 0);
    chk("rst_m0_busy_dbusy", m0_if.busy, 1'b1);
    chk("rst_m1_busy_dbusy", m1_if.busy, 1'b1);
    set_in(1, 32'h10, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0);
    chk("rst_m0_busy_idle", m0_if.busy, 1'b0);
    chk("rst_m1_busy_m0req", m1_if.busy, 1'b1);
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0);
    tick();
    rstn = 1'b1;

    // m0, m1, m0 loads with busy toggling
    exp_acc(0, 32'h100, 0, 0);
    set_in(1, 32'h100, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0); tick();
    set_in(0, 0, 0, 0, 1, 32'h200, 1, 32'h0, 2'b00, 0);
    chk("t1_m1_busy_wait", m1_if.busy, 1'b1);
    tick();
    exp_rsp(2'b01, 2'b00, 2'b00, 0, 0, 32'hAAAA);
    exp_acc(1, 32'h200, 0, 0);
    set_in(0, 0, 0, 0, 1, 32'h200, 0, 32'hAAAA, 2'b00, 0); tick();
    set_in(1, 32'h104, 0, 0, 0, 0, 1, 32'h0, 2'b00, 0); tick();
    exp_rsp(2'b10, 2'b00, 2'b00, 0, 0, 32'hBBBB);
    exp_acc(0, 32'h104, 0, 0);
    set_in(1, 32'h104, 0, 0, 0, 0, 0, 32'hBBBB, 2'b00, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 32'h0, 2'b00, 0); tick();
    exp_rsp(2'b01, 2'b00, 2'b00, 0, 0, 32'hCCCC);
    set_in(0, 0, 0, 0, 0, 0, 0, 32'hCCCC, 2'b00, 0); tick();
    chk("t1_owner_idle", dmem_owner, 2'b00);
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0); tick();

    // simultaneous requests after reset: rr=0 so m0 first, then m1, then m0 again
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    exp_acc(0, 32'h300, 0, 0);
    set_in(1, 32'h300, 0, 0, 1, 32'h400, 0, 32'h0, 2'b00, 0);
    chk("t2_m0_busy", m0_if.busy, 1'b0);
    chk("t2_m1_busy", m1_if.busy, 1'b1);
    tick();
    set_in(0, 0, 0, 0, 1, 32'h400, 1, 32'h0, 2'b00, 0);
    chk("t2_m1_busy_hold", m1_if.busy, 1'b1);
    tick();
    exp_rsp(2'b01, 2'b00, 2'b00, 0, 0, 32'h1111);
    exp_acc(1, 32'h400, 0, 0);
    set_in(0, 0, 0, 0, 1, 32'h400, 0, 32'h1111, 2'b00, 0); tick();
    exp_rsp(2'b10, 2'b00, 2'b00, 0, 0, 32'h2222);
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h2222, 2'b00, 0); tick();
    exp_acc(0, 32'h304, 0, 0);
    set_in(1, 32'h304, 0, 0, 1, 32'h404, 0, 32'h0, 2'b00, 0);
    chk("t2_m1_busy_rr0", m1_if.busy, 1'b1);
    tick();
    exp_rsp(2'b01, 2'b00, 2'b00, 0, 0, 32'h3333);
    exp_acc(1, 32'h404, 0, 0);
    set_in(0, 0, 0, 0, 1, 32'h404, 0, 32'h3333, 2'b00, 0); tick();
    exp_rsp(2'b10, 2'b00, 2'b00, 0, 0, 32'h4444);
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h4444, 2'b00, 0); tick();

    // m0 back-to-back for 10 cycles while m1 keeps requesting
    for (int i = 0; i < 10; i++) begin
      if (i > 0) exp_rsp(2'b01, 2'b00, 2'b00, 0, 0, 32'hD000 + i);
      exp_acc(0, 32'h500 + 4 * i, 0, 0);
      set_in(1, 32'h500 + 4 * i, 0, 0, 1, 32'h600, 0, 32'hD000 + i, 2'b00, 0);
      chk("t3_m1_busy_starved", m1_if.busy, 1'b1);
      tick();
    end
    exp_rsp(2'b01, 2'b00, 2'b00, 0, 0, 32'hD00A);
    exp_acc(1, 32'h600, 0, 0);
    set_in(0, 0, 0, 0, 1, 32'h600, 0, 32'hD00A, 2'b00, 0);
    chk("t3_m1_busy_release", m1_if.busy, 1'b0);
    tick();
    exp_rsp(2'b10, 2'b00, 2'b00, 0, 0, 32'hD00B);
    set_in(0, 0, 0, 0, 0, 0, 0, 32'hD00B, 2'b00, 0); tick();

    // m0 AMO read->write stays atomic against a waiting m1
    exp_acc(0, 32'h700, 0, 1);
    set_in(1, 32'h700, 0, 1, 1, 32'h800, 0, 32'h0, 2'b00, 0); tick();
    set_in(1, 32'h700, 1, 1, 1, 32'h800, 1, 32'h0, 2'b00, 0);
    chk("t4_m1_busy_amo", m1_if.busy, 1'b1);
    tick();
    exp_rsp(2'b01, 2'b00, 2'b00, 1, 0, 32'hE0);
    exp_acc(0, 32'h700, 1, 1);
    set_in(1, 32'h700, 1, 1, 1, 32'h800, 0, 32'hE0, 2'b00, 1);
    chk("t4_m1_busy_cont", m1_if.busy, 1'b1);
    tick();
    set_in(0, 0, 0, 0, 1, 32'h800, 1, 32'h0, 2'b00, 0); tick();
    exp_rsp(2'b01, 2'b00, 2'b00, 1, 0, 32'hE1);
    exp_acc(1, 32'h800, 0, 0);
    set_in(0, 0, 0, 0, 1, 32'h800, 0, 32'hE1, 2'b00, 1); tick();
    exp_rsp(2'b10, 2'b00, 2'b00, 0, 1, 32'hE2);
    set_in(0, 0, 0, 0, 0, 0, 0, 32'hE2, 2'b00, 1); tick();

    // m1 faults on completion while m0 is accepted in the same cycle
    exp_acc(1, 32'h900, 0, 0);
    set_in(0, 0, 0, 0, 1, 32'h900, 0, 32'h0, 2'b00, 0); tick();
    set_in(1, 32'h1000, 0, 0, 0, 0, 1, 32'h0, 2'b00, 0);
    chk("t5_m0_busy_wait", m0_if.busy, 1'b1);
    tick();
    exp_rsp(2'b10, 2'b00, 2'b10, 0, 0, 32'hF0);
    exp_acc(0, 32'h1000, 0, 0);
    set_in(1, 32'h1000, 0, 0, 0, 0, 0, 32'hF0, 2'b10, 0); tick();
    chk("t5_owner_switch", dmem_owner, 2'b01);
    exp_rsp(2'b01, 2'b00, 2'b00, 0, 0, 32'hF1);
    set_in(0, 0, 0, 0, 0, 0, 0, 32'hF1, 2'b00, 0); tick();

    // reset mid-transaction: owner clears at once, late response goes nowhere
    exp_acc(1, 32'hA00, 0, 0);
    set_in(0, 0, 0, 0, 1, 32'hA00, 0, 32'h0, 2'b00, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 32'h0, 2'b00, 0);
    chk("t6_owner_before_rst", dmem_owner, 2'b10);
    rstn = 1'b0;
    #1;
    chk("t6_owner_async_clear", dmem_owner, 2'b00);
    tick();
    rstn = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b01, 1);
    chk("t6_m0_bad_orphan", m0_if.bad, 2'b00);
    chk("t6_m1_bad_orphan", m1_if.bad, 2'b00);
    chk("t6_m0_xstate_orphan", m0_if.xstate, 1'b0);
    chk("t6_m1_xstate_orphan", m1_if.xstate, 1'b0);
    chk("t6_owner_after_rst", dmem_owner, 2'b00);
    tick();

    chk("acc_q_drained", acc_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
